// File: rtl/key_cond_pkg.sv
// Shared types and elaboration helpers for the push-button conditioner.
package key_cond_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } key_state_e;

    // Millisecond interval to clock cycles; never returns 0 so counters always have a terminal value.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
        int unsigned cyc;
        cyc = (clk_hz / 32'd1000) * ms;
        return (cyc == 32'd0) ? 32'd1 : cyc;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce state machine, press pulse.
// Optional auto-repeat pulses while held when KEYCOND_AUTOREPEAT_EN is defined.
module key_debounce_ch
    import key_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 1
`ifdef KEYCOND_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY_CYC  = 1,
    parameter int unsigned REPEAT_PERIOD_CYC = 1
`endif
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key_n,
    output logic level,
    output logic pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]       sync;
    logic             pressed_s;
    key_state_e       state;
    logic [CNT_W-1:0] cnt;

`ifdef KEYCOND_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ?
                                      REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_last;
    logic             rpt_first;

    // First repeat waits the long delay, later ones the short period.
    assign rpt_last = rpt_first ? RPT_W'(REPEAT_DELAY_CYC - 1) : RPT_W'(REPEAT_PERIOD_CYC - 1);
`endif

    // Reset to released so a held key is seen as a fresh press after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], key_n};
        end
    end

    assign pressed_s = ~sync[1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
`ifdef KEYCOND_AUTOREPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
`endif
        end else begin
            pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (pressed_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(DEBOUNCE_CYC)) begin
                        state <= HELD;
                        cnt   <= '0;
                        pulse <= 1'b1;
                        level <= 1'b1;
`ifdef KEYCOND_AUTOREPEAT_EN
                        rpt_cnt   <= '0;
                        rpt_first <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!pressed_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_W'(1);
                    end
`ifdef KEYCOND_AUTOREPEAT_EN
                    else if (rpt_cnt == rpt_last) begin
                        pulse     <= 1'b1;
                        rpt_cnt   <= '0;
                        rpt_first <= 1'b0;
                    end else begin
                        rpt_cnt <= rpt_cnt + RPT_W'(1);
                    end
`endif
                end
                RELEASE_WAIT: begin
                    // Repeat counter holds its value here so a release bounce does not restart it.
                    if (pressed_s) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(DEBOUNCE_CYC)) begin
                        state <= IDLE;
                        cnt   <= '0;
                        level <= 1'b0;
`ifdef KEYCOND_AUTOREPEAT_EN
                        rpt_cnt   <= '0;
                        rpt_first <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Debounced level and press pulse for NUM_KEYS active-low push-buttons.
// Define KEYCOND_AUTOREPEAT_EN to add hold-to-repeat pulses.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int unsigned NUM_KEYS         = 3,
    parameter int unsigned CLK_HZ           = 50_000_000,
    parameter int unsigned DEBOUNCE_MS      = 20,
    parameter int unsigned REPEAT_DELAY_MS  = 500,
    parameter int unsigned REPEAT_PERIOD_MS = 100
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_pulse
);

    localparam int unsigned DEBOUNCE_CYC = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
`ifdef KEYCOND_AUTOREPEAT_EN
    localparam int unsigned REPEAT_DELAY_CYC  = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
    localparam int unsigned REPEAT_PERIOD_CYC = ms_to_cycles(CLK_HZ, REPEAT_PERIOD_MS);
`endif

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYC     (DEBOUNCE_CYC)
`ifdef KEYCOND_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
            .REPEAT_PERIOD_CYC(REPEAT_PERIOD_CYC)
`endif
        ) u_ch (
            .clock  (clock),
            .reset_n(reset_n),
            .key_n  (key_n[i]),
            .level  (key_level[i]),
            .pulse  (key_pulse[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: stimulus queues expected pulses/levels, a monitor checks them.
module tb_key_conditioner;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [2:0] key_n;
    logic [2:0] key_level;
    logic [2:0] key_pulse;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct packed {
        int         cyc;
        logic [2:0] val;
    } exp_t;

    exp_t pulse_q[$];
    exp_t level_q[$];

    key_conditioner #(
        .NUM_KEYS        (3),
        .CLK_HZ          (1000),
        .DEBOUNCE_MS     (4),
        .REPEAT_DELAY_MS (10),
        .REPEAT_PERIOD_MS(5)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .key_n    (key_n),
        .key_level(key_level),
        .key_pulse(key_pulse)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: pops expectations as the DUT presents pulses or as level check points arrive.
    always @(negedge clock) begin : mon
        exp_t e;
        if (key_pulse != 3'b000) begin
            total++;
            if (pulse_q.size() == 0) begin
                bad++;
                $display("FAIL pulse_unexpected cyc=%0d got=%b want=none", cyc, key_pulse);
            end else begin
                e = pulse_q.pop_front();
                if (e.cyc != cyc || e.val != key_pulse) begin
                    bad++;
                    $display("FAIL pulse cyc=%0d got=%b want=%b at cyc %0d", cyc, key_pulse, e.val, e.cyc);
                end
            end
        end else if (pulse_q.size() > 0 && pulse_q[0].cyc <= cyc) begin
            e = pulse_q.pop_front();
            total++;
            bad++;
            $display("FAIL pulse_missing cyc=%0d got=%b want=%b", cyc, key_pulse, e.val);
        end
        if (level_q.size() > 0 && level_q[0].cyc <= cyc) begin
            e = level_q.pop_front();
            total++;
            if (e.cyc != cyc || key_level != e.val) begin
                bad++;
                $display("FAIL level cyc=%0d got=%b want=%b at cyc %0d", cyc, key_level, e.val, e.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic exp_pulse(input int c, input logic [2:0] v);
        pulse_q.push_back('{cyc: c, val: v});
    endtask

    task automatic exp_level(input int c, input logic [2:0] v);
        level_q.push_back('{cyc: c, val: v});
    endtask

    initial begin : stim
        int t0;
        reset_n = 1'b0;
        key_n   = 3'b111;
        exp_level(2, 3'b000);
        tick(3);
        reset_n = 1'b1;
        exp_level(cyc + 3, 3'b000);
        tick(5);

        // Clean press on key 0 for 20 cycles
        t0 = cyc + 1;
        exp_pulse(t0 + 6, 3'b001);
`ifdef KEYCOND_AUTOREPEAT_EN
        exp_pulse(t0 + 16, 3'b001);
        exp_pulse(t0 + 21, 3'b001);
`endif
        exp_level(t0 + 5, 3'b000);
        exp_level(t0 + 6, 3'b001);
        exp_level(t0 + 25, 3'b001);
        exp_level(t0 + 26, 3'b000);
        key_n[0] = 1'b0;
        tick(20);
        key_n[0] = 1'b1;
        tick(16);

        // Press bounce on key 1: no pulse, level stays low
        t0 = cyc + 1;
        exp_level(t0 + 3, 3'b000);
        exp_level(t0 + 6, 3'b000);
        exp_level(t0 + 9, 3'b000);
        key_n[1] = 1'b0; tick(2);
        key_n[1] = 1'b1; tick(1);
        key_n[1] = 1'b0; tick(2);
        key_n[1] = 1'b1; tick(12);

        // Simultaneous press of keys 0 and 2
        t0 = cyc + 1;
        exp_pulse(t0 + 6, 3'b101);
        exp_level(t0 + 6, 3'b101);
        exp_level(t0 + 15, 3'b101);
        exp_level(t0 + 16, 3'b000);
        key_n = 3'b010;
        tick(10);
        key_n = 3'b111;
        tick(14);

        // Release bounce on key 2
        t0 = cyc + 1;
        exp_pulse(t0 + 6, 3'b100);
        exp_level(t0 + 6, 3'b100);
        exp_level(t0 + 16, 3'b100);
        exp_level(t0 + 20, 3'b100);
        exp_level(t0 + 21, 3'b000);
        key_n[2] = 1'b0; tick(12);
        key_n[2] = 1'b1; tick(2);
        key_n[2] = 1'b0; tick(1);
        key_n[2] = 1'b1; tick(20);

        // Reset for one cycle mid-press on key 0, key still held afterwards
        t0 = cyc + 1;
        exp_level(t0 + 3, 3'b000);
        exp_level(t0 + 4, 3'b000);
        exp_level(t0 + 10, 3'b000);
        exp_level(t0 + 11, 3'b001);
        exp_pulse(t0 + 11, 3'b001);
        exp_level(t0 + 20, 3'b001);
        exp_level(t0 + 21, 3'b000);
        key_n[0] = 1'b0;
        tick(4);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(10);
        key_n[0] = 1'b1;
        tick(16);

        // Long hold on key 1 (30 cycles)
        t0 = cyc + 1;
        exp_pulse(t0 + 6, 3'b010);
`ifdef KEYCOND_AUTOREPEAT_EN
        exp_pulse(t0 + 16, 3'b010);
        exp_pulse(t0 + 21, 3'b010);
        exp_pulse(t0 + 26, 3'b010);
        exp_pulse(t0 + 31, 3'b010);
`endif
        exp_level(t0 + 6, 3'b010);
        exp_level(t0 + 35, 3'b010);
        exp_level(t0 + 36, 3'b000);
        key_n[1] = 1'b0;
        tick(30);
        key_n[1] = 1'b1;
        tick(16);

        for (int i = 0; i < 200 && (pulse_q.size() > 0 || level_q.size() > 0); i++) tick(1);
        if (pulse_q.size() > 0 || level_q.size() > 0) begin
            $display("FAIL drain pending_pulses=%0d pending_levels=%0d want=0", pulse_q.size(), level_q.size());
            $fatal(1);
        end
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
